// File: rtl/event_timestamp_logger.sv
// Event timestamp logger: samples d every rising clk edge, and on each level
// change pushes {new level, cycle timestamp} into a small FIFO that a
// downstream reader drains with a registered pop handshake.
module event_timestamp_logger #(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [TS_W-1:0]   rd_ts,
  output logic              rd_level,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Storage: each entry packs {level, timestamp}.
  logic [TS_W:0]     mem_q [DEPTH];

  logic [TS_W-1:0]   time_cnt_q, time_cnt_d;
  logic              d_prev_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic [TS_W-1:0]   rd_ts_q, rd_ts_d;
  logic              rd_level_q, rd_level_d;

  logic              event_det;
  logic              do_pop;
  logic              do_push;

  // Event detection and push/pop qualification.
  // A pop on a full FIFO frees a slot on the same edge, so the push may use it;
  // the slot written equals the slot read, and the read sees the old contents.
  always_comb begin
    event_det = (d != d_prev_q);
    do_pop    = rd_en && !empty_q;
    do_push   = event_det && (!full_q || do_pop);
  end

  // Next-state for counter, pointers, flags and read-data registers.
  always_comb begin
    time_cnt_d = time_cnt_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_ts_d    = rd_ts_q;
    rd_level_d = rd_level_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (event_det && !do_push) begin
      overflow_d = 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      rd_valid_d = 1'b1;
      rd_ts_d    = mem_q[rd_ptr_q][TS_W-1:0];
      rd_level_d = mem_q[rd_ptr_q][TS_W];
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  // State registers with synchronous reset; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_cnt_q <= '0;
      d_prev_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ts_q    <= '0;
      rd_level_q <= 1'b0;
    end else begin
      time_cnt_q <= time_cnt_d;
      d_prev_q   <= d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_ts_q    <= rd_ts_d;
      rd_level_q <= rd_level_d;
    end
  end

  // Entry storage write; contents need no reset since pointers gate access.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= {d, time_cnt_q};
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_ts    = rd_ts_q;
  assign rd_level = rd_level_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_timestamp_logger.sv
// Directed self-checking bench for event_timestamp_logger: a default-width
// instance for the main scenarios and a TS_W=4 instance for timestamp wrap.
module tb_event_timestamp_logger;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (TS_W=16, DEPTH=8)
  logic        rst, d, rd_en;
  logic        rd_valid, rd_level, empty, full, overflow;
  logic [15:0] rd_ts;
  logic [3:0]  count;

  // Narrow-timestamp instance (TS_W=4)
  logic        rst4, d4, rd_en4;
  logic        rd_valid4, rd_level4, empty4, full4, overflow4;
  logic [3:0]  rd_ts4;
  logic [3:0]  count4;

  int checks = 0;
  int failures = 0;

  event_timestamp_logger #(.TS_W(16), .DEPTH(8), .ADDR_W(3)) u_dut (
    .clk(clk), .rst(rst), .d(d), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_level(rd_level),
    .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  event_timestamp_logger #(.TS_W(4), .DEPTH(8), .ADDR_W(3)) u_dut4 (
    .clk(clk), .rst(rst4), .d(d4), .rd_en(rd_en4),
    .rd_valid(rd_valid4), .rd_ts(rd_ts4), .rd_level(rd_level4),
    .empty(empty4), .full(full4), .count(count4), .overflow(overflow4)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic dval);
    rst = 1'b1; d = dval; rd_en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; d4 = 1'b0; rd_en4 = 1'b0;
    do_reset(1'b0);
    rst4 = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_ts !== 16'd0 || rd_level !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd: valid=%b ts=%0d level=%b required 0/0/0", rd_valid, rd_ts, rd_level);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d ovf=%b required 1/0/0/0", empty, full, count, overflow);
    end
  endtask

  task automatic test_toggle();
    do_reset(1'b0);
    repeat (3) step();          // edges 0..2 with d=0
    d = 1'b1; step();           // edge 3: event ts=3
    repeat (3) step();          // edges 4..6
    d = 1'b0; step();           // edge 7: event ts=7
    checks++;
    if (count !== 4'd2 || empty !== 1'b0) begin
      failures++;
      $display("FAIL toggle_count: count=%0d empty=%b required 2/0", count, empty);
    end
    rd_en = 1'b1; step();
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd3 || rd_level !== 1'b1) begin
      failures++;
      $display("FAIL toggle_pop1: valid=%b ts=%0d level=%b required 1/3/1", rd_valid, rd_ts, rd_level);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd7 || rd_level !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL toggle_pop2: valid=%b ts=%0d level=%b empty=%b required 1/7/0/1", rd_valid, rd_ts, rd_level, empty);
    end
    rd_en = 1'b0; step();
    checks++;
    if (rd_valid !== 1'b0 || rd_ts !== 16'd7 || rd_level !== 1'b0) begin
      failures++;
      $display("FAIL toggle_hold: valid=%b ts=%0d level=%b required 0/7/0", rd_valid, rd_ts, rd_level);
    end
  endtask

  task automatic test_power_on_event();
    do_reset(1'b1);
    step();                     // first edge out of reset: event ts=0 level=1
    checks++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL poweron_count: count=%0d required 1", count);
    end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd0 || rd_level !== 1'b1) begin
      failures++;
      $display("FAIL poweron_entry: valid=%b ts=%0d level=%b required 1/0/1", rd_valid, rd_ts, rd_level);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset(1'b0);
    step(); step();             // edges 0,1
    for (int i = 0; i < 9; i++) begin
      d = ~d; step();           // events at edges 2..10
      if (i == 6) begin
        checks++;
        if (full !== 1'b0 || count !== 4'd7) begin
          failures++;
          $display("FAIL fill_7: full=%b count=%0d required 0/7", full, count);
        end
      end
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL fill_8: full=%b count=%0d ovf=%b required 1/8/0", full, count, overflow);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_ovf: full=%b count=%0d ovf=%b required 1/8/1", full, count, overflow);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_ts !== 16'(2 + i) || rd_level !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL fill_drain%0d: valid=%b ts=%0d level=%b required 1/%0d/%b", i, rd_valid, rd_ts, rd_level, 2 + i, (i % 2) == 0);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_after: empty=%b count=%0d ovf=%b required 1/0/1", empty, count, overflow);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset(1'b0);
    step(); step();
    for (int i = 0; i < 8; i++) begin
      d = ~d; step();           // events ts 2..9, d ends at 0
    end
    d = 1'b1; rd_en = 1'b1; step();   // edge 10: pop ts=2, push ts=10
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd2 || rd_level !== 1'b1 || count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ppfull_edge: valid=%b ts=%0d level=%b count=%0d full=%b ovf=%b required 1/2/1/8/1/0",
               rd_valid, rd_ts, rd_level, count, full, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_ts !== 16'(3 + i) || rd_level !== ((i % 2) == 1)) begin
        failures++;
        $display("FAIL ppfull_drain%0d: valid=%b ts=%0d level=%b required 1/%0d/%b", i, rd_valid, rd_ts, rd_level, 3 + i, (i % 2) == 1);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ppfull_after: empty=%b ovf=%b required 1/0", empty, overflow);
    end
  endtask

  task automatic test_read_empty_push();
    do_reset(1'b0);
    step(); step();
    d = 1'b1; rd_en = 1'b1; step();   // edge 2: pop ignored, push ts=2
    checks++;
    if (rd_valid !== 1'b0 || count !== 4'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL rdempty_edge: valid=%b count=%0d empty=%b required 0/1/0", rd_valid, count, empty);
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_ts !== 16'd2 || rd_level !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL rdempty_pop: valid=%b ts=%0d level=%b count=%0d required 1/2/1/0", rd_valid, rd_ts, rd_level, count);
    end
  endtask

  task automatic test_wrap_and_reset();
    rst4 = 1'b1; d4 = 1'b0; rd_en4 = 1'b0;
    step(); step();
    rst4 = 1'b0;
    repeat (15) step();          // edges 0..14
    d4 = 1'b1; step();           // edge 15: ts=15
    step();                      // edge 16 (ts would be 0)
    d4 = 1'b0; step();           // edge 17: ts=1
    checks++;
    if (count4 !== 4'd2) begin
      failures++;
      $display("FAIL wrap_count: count=%0d required 2", count4);
    end
    rd_en4 = 1'b1; step();
    checks++;
    if (rd_valid4 !== 1'b1 || rd_ts4 !== 4'd15 || rd_level4 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pop1: valid=%b ts=%0d level=%b required 1/15/1", rd_valid4, rd_ts4, rd_level4);
    end
    step();
    rd_en4 = 1'b0;
    checks++;
    if (rd_valid4 !== 1'b1 || rd_ts4 !== 4'd1 || rd_level4 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pop2: valid=%b ts=%0d level=%b required 1/1/0", rd_valid4, rd_ts4, rd_level4);
    end
    // Overfill so overflow is set, then reset mid-operation with a pop pending.
    for (int i = 0; i < 9; i++) begin
      d4 = ~d4; step();
    end
    checks++;
    if (count4 !== 4'd8 || overflow4 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_prefill: count=%0d ovf=%b required 8/1", count4, overflow4);
    end
    rst4 = 1'b1; rd_en4 = 1'b1; step();
    rst4 = 1'b0; rd_en4 = 1'b0;
    checks++;
    if (count4 !== 4'd0 || empty4 !== 1'b1 || full4 !== 1'b0 || overflow4 !== 1'b0 || rd_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset: count=%0d empty=%b full=%b ovf=%b valid=%b required 0/1/0/0/0",
               count4, empty4, full4, overflow4, rd_valid4);
    end
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; rd_en = 1'b0;
    rst4 = 1'b1; d4 = 1'b0; rd_en4 = 1'b0;
    #1;
    test_reset();
    test_toggle();
    test_power_on_event();
    test_fill_overflow();
    test_push_pop_full();
    test_read_empty_push();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
